arith_pipe_core: RTL and testbench

//   Parametrised two-stage arithmetic execution core: register file + ALU + writeback register.

---
 rtl/arith_pipe_core.sv | 167 ++++++++++++++++
 tb/tb_arith_pipe_core.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_pipe_core.sv
// Two-stage execution core: EX (operand read + ALU) then WB (commit register).
// One WB->EX forward path; EBREAK drains the pipe and halts.
module arith_pipe_core #(
  parameter  int XLEN      = 32,
  parameter  int NUM_REGS  = 32,
  parameter  int IMM_WIDTH = 12,
  localparam int RA        = $clog2(NUM_REGS),
  localparam int SW        = $clog2(XLEN)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [RA-1:0]        in_dst,
  input  logic [RA-1:0]        in_src1,
  input  logic [RA-1:0]        in_src2,
  input  logic                 in_use_imm,
  input  logic [IMM_WIDTH-1:0] in_imm,
  input  logic                 in_ebreak,
  output logic                 wb_valid,
  output logic [RA-1:0]        wb_dst,
  output logic [XLEN-1:0]      wb_data,
  output logic                 halted,
  output logic                 error,
  input  logic [RA-1:0]        dbg_addr,
  output logic [XLEN-1:0]      dbg_data
);

  logic [XLEN-1:0]      r_regs [NUM_REGS];

  logic                 r_ex_valid;
  logic                 r_ex_ebreak;
  logic                 r_ex_use_imm;
  logic [3:0]           r_ex_op;
  logic [RA-1:0]        r_ex_dst;
  logic [RA-1:0]        r_ex_src1;
  logic [RA-1:0]        r_ex_src2;
  logic [IMM_WIDTH-1:0] r_ex_imm;

  logic                 r_wb_valid;
  logic                 r_wb_ebreak;
  logic [RA-1:0]        r_wb_dst;
  logic [XLEN-1:0]      r_wb_data;

  logic                 r_halted;
  logic                 r_error;
  logic                 r_ebreak_seen;

  logic                 w_accept;
  logic                 w_fwd_a;
  logic                 w_fwd_b;
  logic [XLEN-1:0]      w_a;
  logic [XLEN-1:0]      w_b;
  logic [XLEN-1:0]      w_imm_x;
  logic [XLEN-1:0]      w_res;
  logic                 w_op_ok;
  logic                 w_ex_alu;
  logic [SW-1:0]        w_sh;

  assign in_ready = reset_n && !r_halted && !r_ebreak_seen;
  assign w_accept = in_valid && in_ready;

  assign wb_valid = r_wb_valid;
  assign wb_dst   = r_wb_dst;
  assign wb_data  = r_wb_data;
  assign halted   = r_halted;
  assign error    = r_error;
  assign dbg_data = r_regs[dbg_addr];

  // Only WB can hold a value newer than the regfile; r0 never forwards.
  assign w_fwd_a = r_wb_valid && (r_wb_dst == r_ex_src1)
                && (r_ex_src1 != '0);
  assign w_fwd_b = r_wb_valid && (r_wb_dst == r_ex_src2)
                && (r_ex_src2 != '0);

  assign w_imm_x = {{(XLEN-IMM_WIDTH){r_ex_imm[IMM_WIDTH-1]}},
                    r_ex_imm};

  assign w_a = w_fwd_a ? r_wb_data : r_regs[r_ex_src1];
  assign w_b = r_ex_use_imm ? w_imm_x
             : (w_fwd_b ? r_wb_data : r_regs[r_ex_src2]);
  assign w_sh = w_b[SW-1:0];

  always_comb begin
    w_res   = '0;
    w_op_ok = 1'b1;
    case (r_ex_op)
      4'd0:    w_res = w_a + w_b;
      4'd1:    w_res = w_a - w_b;
      4'd2:    w_res = w_a & w_b;
      4'd3:    w_res = w_a | w_b;
      4'd4:    w_res = w_a ^ w_b;
      4'd5:    w_res = w_a << w_sh;
      4'd6:    w_res = w_a >> w_sh;
      4'd7:    w_res = $signed(w_a) >>> w_sh;
      4'd8:    w_res = {{(XLEN-1){1'b0}},
                        $signed(w_a) < $signed(w_b)};
      4'd9:    w_res = {{(XLEN-1){1'b0}}, w_a < w_b};
      default: w_op_ok = 1'b0;
    endcase
  end

  assign w_ex_alu = r_ex_valid && !r_ex_ebreak && w_op_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_ebreak  <= 1'b0;
      r_ex_use_imm <= 1'b0;
      r_ex_op      <= '0;
      r_ex_dst     <= '0;
      r_ex_src1    <= '0;
      r_ex_src2    <= '0;
      r_ex_imm     <= '0;
    end else begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_ebreak  <= in_ebreak;
        r_ex_use_imm <= in_use_imm;
        r_ex_op      <= in_op;
        r_ex_dst     <= in_dst;
        r_ex_src1    <= in_src1;
        r_ex_src2    <= in_src2;
        r_ex_imm     <= in_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid  <= 1'b0;
      r_wb_ebreak <= 1'b0;
      r_wb_dst    <= '0;
      r_wb_data   <= '0;
    end else begin
      r_wb_valid  <= w_ex_alu;
      r_wb_ebreak <= r_ex_valid && r_ex_ebreak;
      if (w_ex_alu) begin
        r_wb_dst  <= r_ex_dst;
        r_wb_data <= w_res;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_halted      <= 1'b0;
      r_error       <= 1'b0;
      r_ebreak_seen <= 1'b0;
    end else begin
      if (w_accept && in_ebreak) r_ebreak_seen <= 1'b1;
      if (r_wb_ebreak)           r_halted      <= 1'b1;
      if (r_ex_valid && !r_ex_ebreak && !w_op_ok)
        r_error <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (r_wb_valid && (r_wb_dst != '0)) begin
      r_regs[r_wb_dst] <= r_wb_data;
    end
  end

endmodule

// File: tb/tb_arith_pipe_core.sv
// Scoreboard bench: drives a 32/32 and a 16/8 core with the same stream
// and checks commits, flags and final register contents against a model.
module tb_arith_pipe_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [4:0]  in_dst, in_src1, in_src2;
  logic        in_use_imm;
  logic [11:0] in_imm;
  logic        in_ebreak;
  logic [4:0]  dbg_a32;
  logic [2:0]  dbg_a16;

  logic        rdy32, wbv32, hlt32, err32;
  logic [4:0]  wbd32;
  logic [31:0] wbx32, dbg32;
  logic        rdy16, wbv16, hlt16, err16;
  logic [2:0]  wbd16;
  logic [15:0] wbx16, dbg16;

  always #5 clk = ~clk;

  arith_pipe_core #(.XLEN(32), .NUM_REGS(32), .IMM_WIDTH(12)) u32 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_op(in_op), .in_dst(in_dst),
    .in_src1(in_src1), .in_src2(in_src2),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_ebreak(in_ebreak),
    .wb_valid(wbv32), .wb_dst(wbd32), .wb_data(wbx32),
    .halted(hlt32), .error(err32),
    .dbg_addr(dbg_a32), .dbg_data(dbg32)
  );

  arith_pipe_core #(.XLEN(16), .NUM_REGS(8), .IMM_WIDTH(12)) u16 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(rdy16),
    .in_op(in_op), .in_dst(in_dst[2:0]),
    .in_src1(in_src1[2:0]), .in_src2(in_src2[2:0]),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_ebreak(in_ebreak),
    .wb_valid(wbv16), .wb_dst(wbd16), .wb_data(wbx16),
    .halted(hlt16), .error(err16),
    .dbg_addr(dbg_a16), .dbg_data(dbg16)
  );

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] data;
    int          cyc;
  } wb_t;

  wb_t         q32[$];
  wb_t         q16[$];
  logic [31:0] m32 [32];
  logic [31:0] m16 [8];
  logic        m_ebk;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3;
  localparam logic [3:0] XOR = 4'd4, SLL = 4'd5, SRL = 4'd6, SRA = 4'd7;
  localparam logic [3:0] SLT = 4'd8, SLTU = 4'd9;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_m(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] mk, r, sa, sb;
    int sh;
    mk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sh = int'(b) & (w - 1);
    sa = a[w-1] ? (a | ~mk) : a;
    sb = b[w-1] ? (b | ~mk) : b;
    case (op)
      ADD:     r = a + b;
      SUB:     r = a - b;
      AND:     r = a & b;
      OR:      r = a | b;
      XOR:     r = a ^ b;
      SLL:     r = a << sh;
      SRL:     r = a >> sh;
      SRA:     r = $signed(sa) >>> sh;
      SLT:     r = {31'b0, $signed(sa) < $signed(sb)};
      SLTU:    r = {31'b0, a < b};
      default: r = '0;
    endcase
    return r & mk;
  endfunction

  always @(negedge clk) begin
    wb_t e;
    if (reset_n) begin
      if (wbv32) begin
        if (q32.size() == 0) chk("wb32_spurious", 1, 0);
        else begin
          e = q32.pop_front();
          chk("wb32_dst", {27'b0, wbd32}, {27'b0, e.dst});
          chk("wb32_data", wbx32, e.data);
          chk("wb32_lat", cyc, e.cyc);
        end
      end
      if (wbv16) begin
        if (q16.size() == 0) chk("wb16_spurious", 1, 0);
        else begin
          e = q16.pop_front();
          chk("wb16_dst", {29'b0, wbd16}, {29'b0, e.dst[2:0]});
          chk("wb16_data", {16'b0, wbx16}, e.data);
          chk("wb16_lat", cyc, e.cyc);
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m32[i] = '0;
    for (int i = 0; i < 8; i++) m16[i] = '0;
    m_ebk = 1'b0;
    q32.delete();
    q16.delete();
  endtask

  task automatic issue(input logic [3:0] op, input int d, input int s1,
                       input int s2, input logic ui, input int imm,
                       input logic ebk);
    logic [31:0] b, r;
    wb_t e;
    in_valid   = 1'b1;
    in_op      = op;
    in_dst     = 5'(d);
    in_src1    = 5'(s1);
    in_src2    = 5'(s2);
    in_use_imm = ui;
    in_imm     = 12'(imm);
    in_ebreak  = ebk;
    #1;
    chk("in_ready32", {31'b0, rdy32}, {31'b0, !m_ebk});
    chk("in_ready16", {31'b0, rdy16}, {31'b0, !m_ebk});
    if (!m_ebk) begin
      if (ebk) m_ebk = 1'b1;
      else if (op <= 4'd9) begin
        b = ui ? {{20{in_imm[11]}}, in_imm} : m32[s2];
        r = alu_m(op, m32[s1], b, 32);
        if (d != 0) m32[d] = r;
        e.dst = 5'(d); e.data = r; e.cyc = cyc + 2;
        q32.push_back(e);
        b = ui ? ({{20{in_imm[11]}}, in_imm} & 32'hFFFF)
               : m16[s2 & 7];
        r = alu_m(op, m16[s1 & 7], b, 16);
        if ((d & 7) != 0) m16[d & 7] = r;
        e.dst = 5'(d & 7); e.data = r; e.cyc = cyc + 2;
        q16.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_ebreak = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flags(input string tag, input logic h, input logic e);
    chk({tag, "_halt32"}, {31'b0, hlt32}, {31'b0, h});
    chk({tag, "_halt16"}, {31'b0, hlt16}, {31'b0, h});
    chk({tag, "_err32"}, {31'b0, err32}, {31'b0, e});
    chk({tag, "_err16"}, {31'b0, err16}, {31'b0, e});
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_ebreak = 1'b0;
    model_clear();
    #1;
    chk("rst_ready32", {31'b0, rdy32}, 0);
    chk("rst_wbv32", {31'b0, wbv32}, 0);
    chk("rst_wbdata32", wbx32, 0);
    chk("rst_wbv16", {31'b0, wbv16}, 0);
    flags("rst", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_a32 = 5'(i);
      #1;
      chk($sformatf("%s_r32_%0d", tag, i), dbg32, m32[i]);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_a16 = 3'(i);
      #1;
      chk($sformatf("%s_r16_%0d", tag, i), {16'b0, dbg16}, m16[i]);
    end
  endtask

  task automatic reg_is(input string tag, input int i,
                        input logic [31:0] exp);
    dbg_a32 = 5'(i);
    #1;
    chk(tag, dbg32, exp);
  endtask

  task automatic prog(input int gap);
    issue(ADD, 1, 0, 0, 1, 10, 0); idle(gap);
    issue(ADD, 1, 1, 0, 1, 40, 0); idle(gap);
    issue(ADD, 2, 1, 0, 1, 10, 0); idle(gap);
    issue(ADD, 3, 2, 0, 1, 1, 0);  idle(gap);
    issue(ADD, 4, 3, 0, 1, 1, 0);  idle(gap);
    issue(SUB, 5, 4, 1, 0, 0, 0);  idle(gap);
    issue(AND, 6, 1, 2, 0, 0, 0);  idle(gap);
    issue(ADD, 0, 0, 0, 0, 0, 1);
    flags("ebk_k", 1'b0, 1'b0);
    idle(1);
    flags("ebk_k1", 1'b0, 1'b0);
    idle(1);
    flags("ebk_k2", 1'b1, 1'b0);
    reg_is("p_r1", 1, 50);
    reg_is("p_r2", 2, 60);
    reg_is("p_r3", 3, 61);
    reg_is("p_r4", 4, 62);
    reg_is("p_r5", 5, 12);
    reg_is("p_r6", 6, 48);
    check_regs("prog");
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_dst = '0;
    in_src1 = '0; in_src2 = '0; in_use_imm = 1'b0;
    in_imm = '0; in_ebreak = 1'b0;
    dbg_a32 = '0; dbg_a16 = '0;
    model_clear();
    #12;

    do_reset();
    check_regs("reset");
    prog(0);

    do_reset();
    prog(1);

    for (int k = 0; k < 5; k++) issue(ADD, 7, 0, 0, 1, 1, 0);
    idle(3);
    reg_is("halt_r7", 7, 0);
    flags("halt_hold", 1'b1, 1'b0);

    do_reset();
    issue(ADD, 1, 0, 0, 1, -1, 0);
    issue(SRA, 2, 1, 0, 1, 4, 0);
    issue(SLTU, 3, 0, 1, 0, 0, 0);
    issue(SLT, 4, 0, 1, 0, 0, 0);
    issue(ADD, 5, 1, 1, 0, 0, 0);
    issue(SLL, 6, 1, 0, 1, 31, 0);
    issue(SRL, 7, 1, 0, 1, 28, 0);
    issue(XOR, 6, 6, 3, 0, 0, 0);
    issue(OR, 4, 4, 7, 0, 0, 0);
    issue(SLT, 3, 1, 0, 0, 0, 0);
    idle(3);
    reg_is("imm_r1", 1, 32'hFFFF_FFFF);
    reg_is("imm_r2", 2, 32'hFFFF_FFFF);
    reg_is("imm_r5", 5, 32'hFFFF_FFFE);
    check_regs("imm");

    do_reset();
    issue(ADD, 0, 0, 0, 1, 5, 0);
    issue(ADD, 1, 0, 0, 0, 0, 0);
    issue(ADD, 2, 0, 0, 1, 7, 0);
    issue(4'd12, 2, 0, 0, 1, 99, 0);
    flags("err_k", 1'b0, 1'b0);
    idle(1);
    flags("err_k1", 1'b0, 1'b1);
    issue(ADD, 3, 2, 0, 1, 3, 0);
    idle(3);
    reg_is("err_r1", 1, 0);
    reg_is("err_r2", 2, 7);
    reg_is("err_r3", 3, 10);
    check_regs("err");

    do_reset();
    issue(4'd13, 1, 0, 0, 0, 0, 0);
    issue(ADD, 1, 0, 0, 1, 9, 0);
    issue(ADD, 2, 0, 0, 1, 8, 0);
    reset_n = 1'b0;
    model_clear();
    #2;
    reset_n = 1'b1;
    #1;
    chk("mid_ready32", {31'b0, rdy32}, 1);
    chk("mid_ready16", {31'b0, rdy16}, 1);
    flags("mid", 1'b0, 1'b0);
    idle(3);
    check_regs("mid");
    prog(0);

    chk("q32_left", q32.size(), 0);
    chk("q16_left", q16.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
